// File: rtl/fba_accumulator.sv
// fba_accumulator: frame accumulator built on the fixed-bounding add.
// A frame opens with start/len in IDLE, takes len operands in ACC at one per
// cycle, then holds the result in DONE until the consumer takes it.
// The upper byte adds exactly. A carry out of it saturates the accumulator to
// 16'hFFFF and raises a sticky flag for the rest of the frame.
module fba_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_sat,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_acc;
    logic [7:0]  r_count;
    logic        r_sat;
    logic        w_accept;
    logic [16:0] w_sum;

    // Fixed-bounding add. Bit 16 of the result is the saturation event.
    // The lower byte has no carry chain. The highest bit position (7..1)
    // where both operands are set forces that bit and every bit below it to
    // one. Bits above that position are XOR. Bit 0 is an OR.
    // Once the accumulator is already saturated, it stays saturated.
    function automatic logic [16:0] fba_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [8:0] hi;
        logic [7:0] mask;
        logic [7:0] lo;
        hi   = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        mask = 8'h00;
        for (int i = 1; i < 8; i++) begin
            if (a[i] & b[i]) begin
                mask = 8'hFF >> (7 - i);
            end
        end
        lo    = (a[7:0] ^ b[7:0]) | mask;
        lo[0] = a[0] | b[0] | mask[0];
        if (hi[8]) begin
            fba_add = {1'b1, 16'hFFFF};
        end else if (a == 16'hFFFF) begin
            fba_add = {1'b0, 16'hFFFF};
        end else begin
            fba_add = {1'b0, hi[7:0], lo};
        end
    endfunction

    assign w_accept  = (r_state == ACC) && in_valid;
    assign w_sum     = fba_add(r_acc, in_data);

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_acc;
    assign out_sat   = r_sat;

    // State register. Reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. start is only considered in IDLE. A zero-length
    // frame goes straight to DONE. The final accept goes directly to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == 8'd0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                if (w_accept && (r_count == 8'd1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accumulator, remaining-operand count and sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= 16'h0000;
            r_count <= 8'd0;
            r_sat   <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_acc   <= 16'h0000;
            r_count <= len;
            r_sat   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum[15:0];
            r_count <= r_count - 8'd1;
            r_sat   <= r_sat | w_sum[16];
        end
    end

endmodule

// File: tb/tb_fba_accumulator.sv
// Self-checking bench for fba_accumulator: a vector table of frames with
// hand-derived results, randomized frames against a behavioural model, and
// directed sequences for back-pressure and asynchronous reset.
module tb_fba_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_ready;
    logic        busy;

    int n_checks;
    int n_fail;

    fba_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] op0;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] op3;
        logic [15:0] exp_d;
        logic        exp_s;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference add written straight from the arithmetic rules.
    function automatic logic [16:0] model_fba(input logic [15:0] a,
                                              input logic [15:0] b);
        int          hi_sum;
        int          top;
        logic [7:0]  lo;
        hi_sum = int'(a[15:8]) + int'(b[15:8]);
        if (hi_sum > 255) return {1'b1, 16'hFFFF};
        if (a == 16'hFFFF) return {1'b0, 16'hFFFF};
        top = -1;
        for (int i = 7; i >= 1; i--) begin
            if (top < 0 && a[i] && b[i]) top = i;
        end
        for (int k = 0; k < 8; k++) begin
            if (top >= 0 && k <= top) lo[k] = 1'b1;
            else if (k == 0)          lo[k] = a[0] | b[0];
            else                      lo[k] = a[k] ^ b[k];
        end
        return {1'b0, hi_sum[7:0], lo};
    endfunction

    task automatic model_frame(input int n, input logic [15:0] ops [16],
                               output logic [15:0] d, output logic s);
        logic [16:0] r;
        d = 16'h0000;
        s = 1'b0;
        for (int k = 0; k < n; k++) begin
            r = model_fba(d, ops[k]);
            d = r[15:0];
            s = s | r[16];
        end
    endtask

    // Runs a frame from IDLE up to DONE. Caller is just after a clock edge.
    // gap_mode: 0 = in_valid always high, 1 = random gaps,
    //           2 = fixed pattern 1,0,0,1,0,1 then high.
    task automatic run_frame(input int n, input logic [15:0] ops [16],
                             input int gap_mode, input string tag,
                             output logic [15:0] d, output logic s);
        int       acc_cnt;
        int       cyc;
        int       last_acc;
        bit       saw_ready;
        logic [5:0] pat;
        pat = 6'b101001;
        start = 1'b1;
        len   = n[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        acc_cnt   = 0;
        cyc       = 0;
        last_acc  = -1;
        saw_ready = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (gap_mode == 1)                  in_valid = ($urandom_range(0, 2) != 0);
            else if (gap_mode == 2 && cyc < 6)  in_valid = pat[cyc];
            else                                in_valid = 1'b1;
            in_data = ops[acc_cnt & 15];
            if (in_ready) saw_ready = 1'b1;
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_acc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, " accepts"}, 32'(acc_cnt), 32'(n));
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        if (n > 0) begin
            check({tag, " latency"}, 32'(cyc - last_acc), 32'd1);
        end else begin
            check({tag, " len0 latency"}, 32'(cyc), 32'd0);
            check({tag, " len0 in_ready"}, 32'(saw_ready), 32'd0);
        end
        d = out_data;
        s = out_sat;
    endtask

    task automatic finish_frame(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    task automatic setv(input int idx, input int n, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] e, input logic [15:0] d,
                        input logic s);
        vecs[idx].n     = n;
        vecs[idx].op0   = a;
        vecs[idx].op1   = b;
        vecs[idx].op2   = c;
        vecs[idx].op3   = e;
        vecs[idx].exp_d = d;
        vecs[idx].exp_s = s;
    endtask

    initial begin
        logic [15:0] ops [16];
        logic [15:0] got_d;
        logic        got_s;
        logic [15:0] exp_d;
        logic        exp_s;
        logic [15:0] held_d;
        int          n;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;

        setv(0,  2, 16'h1234, 16'h0F0F, 16'h0000, 16'h0000, 16'h213F, 1'b0);
        setv(1,  2, 16'hF000, 16'h2000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        setv(2,  1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0);
        setv(3,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        setv(4,  2, 16'h00FF, 16'h00FF, 16'h0000, 16'h0000, 16'h00FF, 1'b0);
        setv(5,  3, 16'hFF00, 16'h00FF, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
        setv(6,  3, 16'hFF00, 16'h00FF, 16'h0003, 16'h0000, 16'hFFFF, 1'b0);
        setv(7,  2, 16'h0006, 16'h0003, 16'h0000, 16'h0000, 16'h0007, 1'b0);
        setv(8,  2, 16'h0101, 16'h0101, 16'h0000, 16'h0000, 16'h0201, 1'b0);
        setv(9,  2, 16'h80AA, 16'h7F55, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        setv(10, 2, 16'h0050, 16'h0030, 16'h0000, 16'h0000, 16'h007F, 1'b0);
        setv(11, 4, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);

        // Asynchronous reset state, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_sat", 32'(out_sat), 32'd0);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;

        // Table-driven frames; the first start lands on the first edge after release.
        for (int v = 0; v < 12; v++) begin
            for (int k = 0; k < 16; k++) ops[k] = 16'h0000;
            ops[0] = vecs[v].op0;
            ops[1] = vecs[v].op1;
            ops[2] = vecs[v].op2;
            ops[3] = vecs[v].op3;
            run_frame(vecs[v].n, ops, 0, $sformatf("vec%0d", v), got_d, got_s);
            check($sformatf("vec%0d out_data", v), 32'(got_d), 32'(vecs[v].exp_d));
            check($sformatf("vec%0d out_sat", v), 32'(got_s), 32'(vecs[v].exp_s));
            finish_frame($sformatf("vec%0d", v));
        end

        // Randomized frames with random in_valid gaps against the model.
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < 16; k++) begin
                ops[k] = 16'($urandom);
                if ($urandom_range(0, 3) != 0) ops[k][15:8] = 8'($urandom_range(0, 31));
            end
            model_frame(n, ops, exp_d, exp_s);
            run_frame(n, ops, 1, $sformatf("rnd%0d", f), got_d, got_s);
            check($sformatf("rnd%0d out_data", f), 32'(got_d), 32'(exp_d));
            check($sformatf("rnd%0d out_sat", f), 32'(got_s), 32'(exp_s));
            finish_frame($sformatf("rnd%0d", f));
        end

        // len=3 with in_valid pattern 1,0,0,1,0,1.
        for (int k = 0; k < 16; k++) ops[k] = 16'($urandom) & 16'h3FFF;
        model_frame(3, ops, exp_d, exp_s);
        run_frame(3, ops, 2, "gapped", got_d, got_s);
        check("gapped out_data", 32'(got_d), 32'(exp_d));
        check("gapped out_sat", 32'(got_s), 32'(exp_s));
        finish_frame("gapped");

        // Back-pressure in DONE with start pulsed; start is ignored throughout.
        for (int k = 0; k < 16; k++) ops[k] = 16'h0000;
        ops[0] = 16'h1234;
        ops[1] = 16'h0F0F;
        run_frame(2, ops, 0, "hold", got_d, got_s);
        held_d = got_d;
        check("hold first data", 32'(held_d), 32'h213F);
        for (int c = 0; c < 5; c++) begin
            start = (c == 1 || c == 2);
            len   = 8'd5;
            @(posedge clk); #1;
            check($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d out_data", c), 32'(out_data), 32'(held_d));
            check($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        check("hold exit out_valid", 32'(out_valid), 32'd0);
        check("hold exit busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("hold start ignored busy", 32'(busy), 32'd0);
        check("hold start ignored in_ready", 32'(in_ready), 32'd0);

        // Asynchronous reset mid-frame after one of four operands.
        start = 1'b1;
        len   = 8'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hF0F0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort partial acc", 32'(out_data), 32'hF0F0);
        check("abort busy before rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort out_data", 32'(out_data), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_sat", 32'(out_sat), 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        for (int k = 0; k < 16; k++) ops[k] = 16'h0000;
        ops[0] = 16'h0050;
        ops[1] = 16'h0030;
        ops[2] = 16'h0101;
        ops[3] = 16'h0006;
        model_frame(4, ops, exp_d, exp_s);
        run_frame(4, ops, 0, "post_rst", got_d, got_s);
        check("post_rst out_data", 32'(got_d), 32'(exp_d));
        check("post_rst out_sat", 32'(got_s), 32'(exp_s));
        finish_frame("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
